// File: rtl/int_divider_seq_pkg.sv
// Shared types and default sizing for the sequential restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
`ifndef INT_DIVIDER_SEQ_PKG_SV
`define INT_DIVIDER_SEQ_PKG_SV
package int_divider_seq_pkg;

    // Default operand width matches the FP32 mantissa including the hidden bit.
    localparam int DIV_WIDTH_DEF = 24;
    // Extra fraction bits give enough quotient bits for guard/round/sticky.
    localparam int DIV_FRAC_DEF  = 26;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage
`endif

// File: rtl/int_divider_seq_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is registered.
module int_div_step #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] p_i,      // partial remainder, always < b_i
    input  logic             n_bit_i,  // next dividend bit (msb of shifted dividend)
    input  logic [WIDTH-1:0] b_i,      // divisor
    output logic [WIDTH-1:0] p_o,      // new partial remainder, always < b_i
    output logic             q_bit_o   // quotient bit produced by this step
);

    // The shifted value needs WIDTH+1 bits so the compare cannot overflow;
    // the result is below b_i again and fits back in WIDTH bits.
    logic [WIDTH:0]   p_shift;
    logic [WIDTH-1:0] diff;

    // Trial subtraction: keep the difference only if it does not go negative.
    always_comb begin
        p_shift = {p_i, n_bit_i};
        diff    = p_shift[WIDTH-1:0] - b_i;
        q_bit_o = (p_shift >= {1'b0, b_i});
        p_o     = q_bit_o ? diff : p_shift[WIDTH-1:0];
    end

endmodule

// File: rtl/int_divider_seq.sv
// Sequential restoring divider: quotient = floor(a*2^FRAC/b), one quotient bit per cycle.
// Latency: result valid WIDTH+FRAC+1 cycles after accept (1 cycle when b==0).
// Backpressure: result held in DONE until out_ready; in_ready only rises in IDLE.
module int_divider_seq
    import int_divider_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF,
    parameter int FRAC  = DIV_FRAC_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH+FRAC-1:0]   quotient,
    output logic [WIDTH-1:0]        remainder,
    output logic                    sticky,
    output logic                    div_by_zero
);

    localparam int QW = WIDTH + FRAC;
    localparam int CW = $clog2(QW + 1);

    div_state_t        state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [QW-1:0]     n_q;          // dividend, consumed msb first
    logic [QW-1:0]     q_q;          // quotient bits accumulated so far
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  p_q;          // partial remainder
    logic [WIDTH-1:0]  p_d;
    logic              q_bit_d;
    logic [CW-1:0]     count_q;      // remaining BUSY cycles

    logic [QW-1:0]     quotient_q;
    logic [WIDTH-1:0]  remainder_q;
    logic              sticky_q;
    logic              div_by_zero_q;

    int_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p_i     (p_q),
        .n_bit_i (n_q[QW-1]),
        .b_i     (b_q),
        .p_o     (p_d),
        .q_bit_o (q_bit_d)
    );

    // Control FSM plus datapath registers; result fields are only loaded on
    // entry to DONE so they stay put after the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            n_q           <= '0;
            q_q           <= '0;
            b_q           <= '0;
            p_q           <= '0;
            count_q       <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            sticky_q      <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        if (b != '0) begin
                            n_q     <= {a, {FRAC{1'b0}}};
                            b_q     <= b;
                            p_q     <= '0;
                            q_q     <= '0;
                            count_q <= CW'(QW);
                            state_q <= ST_BUSY;
                        end else begin
                            // Divide by zero short-circuits straight to a result.
                            quotient_q    <= '1;
                            remainder_q   <= a;
                            sticky_q      <= (a != '0);
                            div_by_zero_q <= 1'b1;
                            out_valid_q   <= 1'b1;
                            state_q       <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    p_q     <= p_d;
                    n_q     <= {n_q[QW-2:0], 1'b0};
                    q_q     <= {q_q[QW-2:0], q_bit_d};
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        // Last step: publish the step output directly.
                        quotient_q    <= {q_q[QW-2:0], q_bit_d};
                        remainder_q   <= p_d;
                        sticky_q      <= (p_d != '0);
                        div_by_zero_q <= 1'b0;
                        out_valid_q   <= 1'b1;
                        state_q       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign sticky      = sticky_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_int_divider_seq.sv
// Self-checking bench for int_divider_seq: directed cases, backpressure, reset abort, random.
// Latency: checks accept-to-valid latency on every operation.
// Backpressure: holds out_ready low in DONE and pokes in_valid while busy.
module tb_int_divider_seq;

    localparam int W  = 24;
    localparam int F  = 26;
    localparam int QW = W + F;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [QW-1:0] quotient;
    logic [W-1:0]  remainder;
    logic          sticky;
    logic          div_by_zero;

    int errors = 0;
    int checks = 0;

    int_divider_seq #(.WIDTH(W), .FRAC(F)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .sticky      (sticky),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one division and check it. hold = extra DONE cycles with out_ready
    // low; poke = throw random in_valid/operand noise at the DUT while busy.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input int hold, input bit poke);
        longint unsigned num, eq, er, exp_lat;
        int lat;
        num = longint'(oa) << F;
        if (ob == 0) begin
            eq      = (64'd1 << QW) - 64'd1;
            er      = 64'(oa);
            exp_lat = 1;
        end else begin
            eq      = num / 64'(ob);
            er      = num % 64'(ob);
            exp_lat = QW + 1;
        end
        check("idle_in_ready", 64'(in_ready), 64'd1);
        a = oa; b = ob; in_valid = 1'b1;
        @(negedge clk);
        lat = 1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom);
        while (!out_valid && lat < 200) begin
            if (in_ready) begin
                errors++;
                $error("FAIL busy_in_ready observed=1 expected=0 at lat=%0d", lat);
            end
            if (poke) in_valid = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("latency", 64'(lat), exp_lat);
        check("quotient", 64'(quotient), eq);
        check("remainder", 64'(remainder), er);
        check("sticky", 64'(sticky), 64'(er != 0));
        check("div_by_zero", 64'(div_by_zero), 64'(ob == 0));
        check("done_in_ready", 64'(in_ready), 64'd0);
        if (ob != 0) begin
            check("identity", 64'(quotient) * 64'(ob) + 64'(remainder), num);
            check("rem_lt_b", 64'(remainder < ob), 64'd1);
        end
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
            end
            @(negedge clk);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_quotient", 64'(quotient), eq);
            check("hold_remainder", 64'(remainder), er);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_out_valid", 64'(out_valid), 64'd0);
        check("post_in_ready", 64'(in_ready), 64'd1);
        check("post_quotient_kept", 64'(quotient), eq);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_quotient", 64'(quotient), 64'd0);
        check("rst_remainder", 64'(remainder), 64'd0);
        check("rst_sticky", 64'(sticky), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);

        // Directed cases.
        do_op(24'h800000, 24'h800000, 0, 1'b0);
        check("dir_1_0_q", 64'(quotient), 64'h4000000);
        do_op(24'hC00000, 24'h800000, 0, 1'b0);
        check("dir_1_5_q", 64'(quotient), 64'h6000000);
        do_op(24'h800000, 24'hC00000, 0, 1'b0);
        check("dir_2_3_q", 64'(quotient), 64'h2AAAAAA);
        check("dir_2_3_r", 64'(remainder), 64'h800000);
        do_op(24'd5, 24'd0, 0, 1'b0);
        check("dbz_q", 64'(quotient), 64'h3FFFFFFFFFFFF);
        check("dbz_r", 64'(remainder), 64'd5);
        do_op(24'd0, 24'h123456, 0, 1'b0);
        check("zero_a_sticky", 64'(sticky), 64'd0);
        do_op(24'hFFFFFF, 24'd1, 0, 1'b0);
        check("ones_by_one_q", 64'(quotient), 64'hFFFFFF << F);

        // Backpressure with noise, then back-to-back accept.
        do_op(24'hABCDEF, 24'h9A5A5A, 10, 1'b1);
        do_op(24'h876543, 24'hF00001, 0, 1'b0);

        // Reset in the middle of BUSY (cycle T+20).
        a = 24'hE12345; b = 24'h812345; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_quotient", 64'(quotient), 64'd0);
        check("abort_remainder", 64'(remainder), 64'd0);
        check("abort_sticky", 64'(sticky), 64'd0);
        check("abort_dbz", 64'(div_by_zero), 64'd0);
        do_op(24'hE12345, 24'h812345, 0, 1'b0);

        // Random: normalized mantissas, then unrestricted operands.
        for (int i = 0; i < 500; i++) begin
            ra = W'($urandom) | 24'h800000;
            rb = W'($urandom) | 24'h800000;
            do_op(ra, rb, 0, 1'b0);
        end
        for (int i = 0; i < 500; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 15) == 0) ? W'(0) : W'($urandom >> $urandom_range(0, 23));
            do_op(ra, rb, $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/int_divider_seq.md
Name: int_divider_seq

Overview:
- Sequential restoring integer divider; the inverse operation of the 24x24 array multiplier.
- Intended as the mantissa datapath of the FP32 divide unit.
- Computes Q = floor(a * 2^FRAC / b) and R = remainder, one quotient bit per cycle.
- Uses a valid/ready handshake on both the input and output sides.

Parameters:
- WIDTH, 24, operand width (dividend a, divisor b).
- FRAC, 26, extra fraction bits appended to the dividend; quotient width QW = WIDTH+FRAC.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  divider idle, can accept operands.
- a  input  WIDTH  dividend.
- b  input  WIDTH  divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  QW  floor(a*2^FRAC/b).
- remainder  output  WIDTH  a*2^FRAC - quotient*b.
- sticky  output  1  remainder != 0.
- div_by_zero  output  1  b was zero.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset state: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, sticky=0, div_by_zero=0.
- Reset mid-operation aborts the division with no result produced. The next cycle is IDLE with the reset values above.
- State IDLE:
  - in_ready=1.
  - Accept occurs when in_valid=1 (cycle T).
  - If b!=0: latch N = {a, FRAC zeros} (QW bits) and b; clear the partial remainder P (WIDTH+1 bits); count=QW; go to BUSY.
  - If b==0: go to DONE with quotient all ones, remainder=a, sticky=(a!=0), div_by_zero=1. out_valid rises at T+1.
- State BUSY:
  - in_ready=0.
  - Each cycle: P' = {P[WIDTH-1:0], N msb}; shift N left by 1.
  - If P' >= b: P = P'-b and shift a 1 into the quotient lsb. Otherwise P = P' and shift in a 0.
  - Decrement count. When count reaches 1 on the current cycle, go to DONE.
  - Exactly QW BUSY cycles occur, in cycles T+1..T+QW.
- State DONE:
  - out_valid=1 from cycle T+QW+1 (b!=0 case).
  - quotient, remainder, sticky and div_by_zero are registered and held stable while out_valid=1 and out_ready=0.
  - On out_ready=1, go to IDLE next cycle; out_valid drops and in_ready rises.
  - in_ready is never high in DONE, so there is no combinational path from out_ready to in_ready. Minimum issue interval is QW+2 cycles.
- Width rules:
  - The partial remainder is WIDTH+1 bits so the compare never overflows. The final remainder is always < b and fits in WIDTH bits.
  - The quotient register is QW bits. For normalized mantissas (a,b in [2^(WIDTH-1), 2^WIDTH)) the quotient lies in [2^(FRAC-1), 2^(FRAC+1)).
- Boundary conditions:
  - in_valid outside IDLE is ignored; operands are not sampled.
  - a=0 gives quotient=0, remainder=0, sticky=0.
  - All-ones a divided by b=1 yields quotient = a<<FRAC and remainder 0; no overflow is possible for any nonzero b.
  - Output fields retain their last values after the handshake until the next DONE. Only out_valid qualifies them.

Decomposition:
- Shared header (`ifndef guarded): state encodings IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
- One sub-module, int_div_step: combinational single restoring step.
  - Inputs: P, next dividend bit, b.
  - Outputs: new P, quotient bit.
- The top level holds the FSM, counter, and shift registers. The counter width is clog2(QW+1).

Test Plan:
- Defaults; a=0x800000, b=0x800000 -> quotient=0x4000000, remainder=0, sticky=0, div_by_zero=0; out_valid rises exactly 51 cycles after the accept cycle.
- a=0xC00000, b=0x800000 -> quotient=0x6000000, remainder=0, sticky=0.
- a=0x800000, b=0xC00000 -> quotient=0x2AAAAAA, remainder=0x800000, sticky=1.
- a=5, b=0 -> div_by_zero=1, quotient=0x3FFFFFFFFFFFF, remainder=5, sticky=1; out_valid one cycle after the accept cycle.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> all outputs stable, in_ready=0; in_valid pulses during BUSY/DONE are ignored. out_ready=1 -> IDLE next cycle, then back-to-back accept with a new result matching the reference model.
- Assert rst mid-BUSY (cycle T+20) -> next cycle in_ready=1, out_valid=0, outputs zeroed. A new operation then completes correctly. Finish with 1000 random normalized and unrestricted operand pairs checked against a*2^FRAC = q*b + r, r < b.
